// File: rtl/quire_window_arbiter.sv
// Shares one quire accumulator among NB_REQ posit-product requesters, one window
// at a time: round-robin grant, sow/eow framing, length cap, owner-tagged results.
module quire_window_arbiter #(
  parameter int unsigned NB_REQ       = 4,
  parameter int unsigned LOG_NB_ACCUM = 10,
  parameter int unsigned TAG_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NB_REQ-1:0]           req_rts_i,
  output logic [NB_REQ-1:0]           req_rtr_o,
  input  logic [NB_REQ-1:0]           req_eow_i,
  input  logic [4*NB_REQ-1:0]         req_fraction_i,
  input  logic [4*NB_REQ-1:0]         req_scale_i,
  input  logic [NB_REQ-1:0]           req_sign_i,
  input  logic [NB_REQ-1:0]           req_zero_i,
  input  logic [NB_REQ-1:0]           req_NaR_i,
  input  logic                        q_rtr_i,
  output logic                        q_rts_o,
  output logic                        q_sow_o,
  output logic                        q_eow_o,
  output logic [3:0]                  q_fraction_o,
  output logic [3:0]                  q_scale_o,
  output logic                        q_sign_o,
  output logic                        q_zero_o,
  output logic                        q_NaR_o,
  input  logic                        res_rts_i,
  input  logic                        res_eow_i,
  input  logic                        res_NaR_i,
  input  logic [18:0]                 res_data_i,
  output logic                        res_rtr_o,
  input  logic                        dn_rtr_i,
  output logic                        dn_rts_o,
  output logic [18:0]                 dn_data_o,
  output logic                        dn_NaR_o,
  output logic [$clog2(NB_REQ)-1:0]   dn_owner_o,
  output logic                        overflow_o,
  output logic                        tag_err_o
);

  localparam int unsigned OW = $clog2(NB_REQ);
  localparam int unsigned TW = $clog2(TAG_DEPTH);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [OW-1:0]           r_rr_ptr, r_owner;
  logic [LOG_NB_ACCUM-1:0] r_beat_cnt;
  logic                    r_first;
  logic [OW-1:0]           r_tag_mem [TAG_DEPTH];
  logic [TW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [TW:0]             r_tag_cnt;
  logic                    r_overflow, r_tag_err;

  logic [OW-1:0]           w_pick;
  logic                    w_found;
  logic                    w_tag_full, w_tag_ne, w_limit;
  logic                    w_accept, w_push, w_pop, w_err;
  int unsigned             w_idx;

  assign w_tag_full = (r_tag_cnt == (TW+1)'(TAG_DEPTH));
  assign w_tag_ne   = (r_tag_cnt != '0);
  assign w_limit    = &r_beat_cnt;

  // Round-robin search: lowest offset from r_rr_ptr wins, hence the descending sweep.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      w_idx = (32'(r_rr_ptr) + (NB_REQ - 1 - k)) % NB_REQ;
      if (req_rts_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = OW'(w_idx);
      end
    end
  end

  // Issue-side FSM and owner-lane pass-through.
  always_comb begin
    w_state_nxt  = r_state;
    req_rtr_o    = '0;
    q_rts_o      = 1'b0;
    q_sow_o      = 1'b0;
    q_eow_o      = 1'b0;
    q_fraction_o = '0;
    q_scale_o    = '0;
    q_sign_o     = 1'b0;
    q_zero_o     = 1'b0;
    q_NaR_o      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        q_rts_o            = req_rts_i[r_owner] & ~w_tag_full;
        req_rtr_o[r_owner] = q_rtr_i & ~w_tag_full;
        q_sow_o            = r_first;
        q_eow_o            = req_eow_i[r_owner] | w_limit;
        q_fraction_o       = req_fraction_i[4*r_owner +: 4];
        q_scale_o          = req_scale_i[4*r_owner +: 4];
        q_sign_o           = req_sign_i[r_owner];
        q_zero_o           = req_zero_i[r_owner];
        q_NaR_o            = req_NaR_i[r_owner];
        w_accept           = req_rts_i[r_owner] & q_rtr_i & ~w_tag_full;
        if (w_accept && q_eow_o) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result side: partial sums are drained silently, eow results carry the FIFO head.
  always_comb begin
    dn_rts_o  = 1'b0;
    res_rtr_o = 1'b1;
    if (res_eow_i && w_tag_ne) begin
      dn_rts_o  = res_rts_i;
      res_rtr_o = dn_rtr_i;
    end
    if (rst) res_rtr_o = 1'b0;
    dn_data_o  = dn_rts_o ? res_data_i : '0;
    dn_NaR_o   = dn_rts_o & res_NaR_i;
    dn_owner_o = w_tag_ne ? r_tag_mem[r_rd_ptr] : '0;
  end

  assign w_push = w_accept & q_eow_o;
  assign w_pop  = dn_rts_o & dn_rtr_i;
  assign w_err  = res_rts_i & res_eow_i & ~w_tag_ne;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_first    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tag_cnt  <= '0;
      r_overflow <= 1'b0;
      r_tag_err  <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) r_tag_mem[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_owner    <= w_pick;
        r_beat_cnt <= '0;
        r_first    <= 1'b1;
      end
      if (w_accept) begin
        r_first <= 1'b0;
        if (q_eow_o) begin
          r_rr_ptr <= (r_owner == OW'(NB_REQ - 1)) ? '0 : r_owner + OW'(1);
          if (!req_eow_i[r_owner]) r_overflow <= 1'b1;
        end else begin
          r_beat_cnt <= r_beat_cnt + LOG_NB_ACCUM'(1);
        end
      end
      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= r_owner;
        r_wr_ptr            <= r_wr_ptr + TW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + TW'(1);
      if (w_push && !w_pop)      r_tag_cnt <= r_tag_cnt + (TW+1)'(1);
      else if (!w_push && w_pop) r_tag_cnt <= r_tag_cnt - (TW+1)'(1);
      if (w_err) r_tag_err <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
  assign tag_err_o  = r_tag_err;

endmodule
